// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants, FSM state encoding and glyph decode function
//
// Optional feature macro: SEG7_HEX_EN (adds the A..F glyphs to glyph_decode).
//
// Contents:
//   GLYPH_0..GLYPH_F, GLYPH_BLANK : 7-bit segment patterns, bit order gfedcba
//   state_e                       : S_IDLE / S_SETTLE / S_HOLD, 2 bits
//   glyph_decode(pattern)         : returns {hit, value[3:0]}

package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  // {hit, value}; hit=0 means the pattern is not a digit glyph (blank included).
  function automatic logic [4:0] glyph_decode(input logic [6:0] pattern);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pattern)
      GLYPH_0: res = {1'b1, 4'd0};
      GLYPH_1: res = {1'b1, 4'd1};
      GLYPH_2: res = {1'b1, 4'd2};
      GLYPH_3: res = {1'b1, 4'd3};
      GLYPH_4: res = {1'b1, 4'd4};
      GLYPH_5: res = {1'b1, 4'd5};
      GLYPH_6: res = {1'b1, 4'd6};
      GLYPH_7: res = {1'b1, 4'd7};
      GLYPH_8: res = {1'b1, 4'd8};
      GLYPH_9: res = {1'b1, 4'd9};
`ifdef SEG7_HEX_EN
      GLYPH_A: res = {1'b1, 4'd10};
      GLYPH_B: res = {1'b1, 4'd11};
      GLYPH_C: res = {1'b1, 4'd12};
      GLYPH_D: res = {1'b1, 4'd13};
      GLYPH_E: res = {1'b1, 4'd14};
      GLYPH_F: res = {1'b1, 4'd15};
`endif
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// rtl/seg7_if.sv - filtered glyph link between the sync filter and the decoder FSM
//
// Signals:
//   pattern : synchronised segment pattern (gfedcba)
//   change  : pattern differs from the previous synchronised sample this cycle
//   stable  : one-cycle strobe, pattern has just become stable for STABLE_CYCLES samples
// Modports: master = producer (filter), slave = consumer (FSM).

interface seg7_if;
  logic [6:0] pattern;
  logic       change;
  logic       stable;

  modport master (output pattern, output change, output stable);
  modport slave  (input  pattern, input  change, input  stable);
endinterface

// File: rtl/seg7_sync_filter.sv
// rtl/seg7_sync_filter.sv - synchroniser chain and stability counter for the segment pattern
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : low freezes the chain and the counter
//   pin        : raw segment pattern from the pads
//   filt       : seg7_if master (pattern / change / stable)

module seg7_sync_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] pin,
  seg7_if.master     filt
);

  localparam logic [7:0] STABLE_U = 8'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
  logic [6:0]                  prev_q, prev_d;
  logic [7:0]                  stab_cnt_q, stab_cnt_d;
  logic [6:0]                  sync_out;
  logic                        differs;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differs  = (sync_out != prev_q);

  always_comb begin
    sync_d     = sync_q;
    prev_d     = prev_q;
    stab_cnt_d = stab_cnt_q;
    if (ena) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin};
      prev_d = sync_out;
      if (differs) begin
        stab_cnt_d = 8'd1;
      end else if (stab_cnt_q < STABLE_U) begin
        stab_cnt_d = stab_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign filt.pattern = sync_out;
  assign filt.change  = ena && differs;
  // Strobe on the edge where the counter arrives at the threshold; a saturated
  // counter only re-strobes if a change restarted it (STABLE_CYCLES == 1).
  assign filt.stable  = ena && (stab_cnt_d == STABLE_U) && (differs || (stab_cnt_q != STABLE_U));

endmodule

// File: rtl/tt_um_seg7_decoder.sv
// rtl/tt_um_seg7_decoder.sv - 7-segment glyph receiver: sync, debounce, decode, count
//
// Optional feature macro: SEG7_HEX_EN (hex glyphs A..F decode to 10..15).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : high = run, low = freeze all state
//   ui_in      : [6:0] segments a..g (bit0 = a), [7] unused
//   uio_in     : unused
//   uo_out     : [3:0] digit, [4] valid pulse, [5] error, [6] blank, [7] 0
//   uio_out    : accepted-glyph count, modulo 256
//   uio_oe     : constant 8'hFF

module tt_um_seg7_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  seg7_if filt_if ();

  seg7_sync_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .pin   (ui_in[6:0]),
    .filt  (filt_if.master)
  );

  logic unused_inputs;
  assign unused_inputs = ^{ui_in[7], uio_in};

  state_e     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       blank_q, blank_d;
  logic [7:0] count_q, count_d;
  logic [6:0] last_q, last_d;

  logic       accept;
  logic       is_blank;
  logic [4:0] dec;

  assign dec      = glyph_decode(filt_if.pattern);
  assign is_blank = (filt_if.pattern == GLYPH_BLANK);
  // The change term covers STABLE_CYCLES == 1, where the strobe coincides with
  // the change and the FSM has not reached SETTLE yet.
  assign accept   = filt_if.stable && ((state_q == S_SETTLE) || filt_if.change);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      blank_q <= 1'b1;
      count_q <= 8'd0;
      last_q  <= GLYPH_BLANK;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      error_q <= error_d;
      blank_q <= blank_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = is_blank ? S_IDLE : S_HOLD;
    end else if (filt_if.change) begin
      state_d = S_SETTLE;
    end
  end

  // Outputs. Everything holds while ena is low, valid included.
  always_comb begin
    digit_d = digit_q;
    valid_d = ena ? 1'b0 : valid_q;
    error_d = error_q;
    blank_d = blank_q;
    count_d = count_q;
    last_d  = last_q;
    if (accept) begin
      // Every accepted pattern becomes the reference, so a digit following a
      // blank or a miss always differs from it and is reported.
      last_d = filt_if.pattern;
      if (is_blank) begin
        blank_d = 1'b1;
        error_d = 1'b0;
      end else if (dec[4]) begin
        if (filt_if.pattern != last_q) begin
          digit_d = dec[3:0];
          valid_d = 1'b1;
          error_d = 1'b0;
          blank_d = 1'b0;
          count_d = count_q + 8'd1;
        end
      end else begin
        error_d = 1'b1;
      end
    end
  end

  assign uo_out  = {1'b0, blank_q, error_q, valid_q, digit_q};
  assign uio_out = count_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_seg7_decoder.sv
// tb/tb_tt_um_seg7_decoder.sv - scoreboard bench for tt_um_seg7_decoder with directed glyph vectors

module tb_tt_um_seg7_decoder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  seg7_if link ();

  assign ui_in       = {1'b0, link.pattern};
  assign link.stable = uo_out[4];
  assign link.change = uo_out[5];

  always #5 clk = ~clk;

  tt_um_seg7_decoder dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

`ifdef SEG7_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  typedef struct {
    logic [3:0] digit;
    logic [7:0] count;
    int         exp_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp   = 0;
  int         n_bad   = 0;
  int         n_valid = 0;
  int         cyc     = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per valid cycle.
  always @(negedge clk) begin
    exp_t e;
    check("uio_oe", uio_oe, 8'hFF);
    if (rst_n && link.stable) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: actual uo_out %0h uio_out %0h required no valid (cycle %0d)",
                 uo_out, uio_out, cyc);
      end else begin
        e = exp_q.pop_front();
        check("digit", uo_out[3:0], e.digit);
        check("count", uio_out, e.count);
        check("error_at_valid", uo_out[5], 1'b0);
        check("blank_at_valid", uo_out[6], 1'b0);
        if (e.exp_cyc >= 0) check("latency", cyc, e.exp_cyc);
      end
    end
  end

  // Apply a pattern at a negedge and keep it for 'hold' further cycles.
  // lat < 0 means latency is not checked for that glyph.
  task automatic drive(input logic [6:0] pat, input int hold, input bit expect_valid,
                       input logic [3:0] dig, input int lat);
    exp_t e;
    @(negedge clk);
    if (expect_valid) begin
      exp_count   = exp_count + 8'd1;
      e.digit     = dig;
      e.count     = exp_count;
      e.exp_cyc   = (lat >= 0) ? cyc + lat : -1;
      exp_q.push_back(e);
    end
    link.pattern = pat;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    int v0;
    link.pattern = 7'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 8'h40);
    check("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_uo_out", uo_out, 8'h40);

    // 1: single glyph, latency SYNC_STAGES + STABLE_CYCLES = 6
    drive(7'h06, 10, 1'b1, 4'd1, 6);
    check("t1_digit", uo_out[3:0], 4'd1);
    check("t1_count", uio_out, 8'h01);

    // 2: three distinct glyphs
    drive(7'h5B, 8, 1'b1, 4'd2, -1);
    drive(7'h4F, 8, 1'b1, 4'd3, -1);
    check("t2_count", uio_out, 8'h03);
    check("t2_error", uo_out[5], 1'b0);

    // 3: one-cycle glitch returning to the accepted glyph
    drive(7'h3F, 8, 1'b1, 4'd0, -1);
    drive(7'h7F, 0, 1'b0, 4'd0, -1);
    drive(7'h3F, 10, 1'b0, 4'd0, -1);
    check("t3_count", uio_out, 8'h04);
    check("t3_digit", uo_out[3:0], 4'd0);

    // 4: hex glyph A, then blank
    drive(7'h77, 8, HEX, 4'd10, -1);
    check("t4_error", link.change, !HEX);
    check("t4_digit", uo_out[3:0], HEX ? 4'd10 : 4'd0);
    drive(7'h00, 8, 1'b0, 4'd0, -1);
    check("t4_blank", uo_out[6], 1'b1);
    check("t4_error_clr", uo_out[5], 1'b0);

    // ena low mid-SETTLE for 10 cycles stretches latency by 10
    drive(7'h66, 3, 1'b1, 4'd4, 16);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    check("ena_freeze_uo_out", uo_out, {4'h4, HEX ? 4'd10 : 4'd0});
    ena = 1'b1;
    repeat (8) @(negedge clk);
    check("ena_digit", uo_out[3:0], 4'd4);

    // 5: 256 alternating glyphs, count wraps through FF -> 00
    v0 = n_valid;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) drive(7'h06, 6, 1'b1, 4'd1, -1);
      else            drive(7'h5B, 6, 1'b1, 4'd2, -1);
    end
    repeat (3) @(negedge clk);
    check("t5_valid_pulses", n_valid - v0, 256);
    check("t5_count", uio_out, exp_count);

    // 6: reset during SETTLE of 6D
    drive(7'h6D, 4, 1'b0, 4'd0, -1);
    rst_n = 1'b0;
    link.pattern = 7'h00;
    exp_count = 8'd0;
    #1;
    check("t6_rst_uo_out", uo_out, 8'h40);
    check("t6_rst_uio_out", uio_out, 8'h00);
    check("t6_rst_uio_oe", uio_oe, 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_after_uo_out", uo_out, 8'h40);
    check("t6_after_count", uio_out, 8'h00);

    check("missing_valids", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
